// File: rtl/alu_rr_arbiter_pkg.sv
// Shared constants, FSM state type and index decode for the ALU round-robin arbiter.
package alu_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT
  } arb_state_t;

  function automatic logic [N_REQ-1:0] decode(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] onehot;
    onehot      = '0;
    onehot[idx] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Request/grant bundle between the ALU requesters and the round-robin arbiter.
interface alu_rr_arbiter_if;
  import alu_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             alu_done;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             alu_start;
  logic             timeout_err;

  // Requester/ALU side drives requests and completion.
  modport master (
    output req,
    output alu_done,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  alu_start,
    input  timeout_err
  );

  modport slave (
    input  req,
    input  alu_done,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output alu_start,
    output timeout_err
  );

endinterface

// File: rtl/alu_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request bit at or above ptr, wrapping 7->0.
module rr_pick
  import alu_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_valid
);

  // Scan from the farthest offset down so the nearest candidate overwrites last.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand      = '0;
    win_idx   = '0;
    win_valid = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) begin
        win_idx   = cand;
        win_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sequencing one ALU transaction at a time (grant, start pulse, wait for done).
// Optional forced release after TIMEOUT WAIT cycles when ALU_ARB_TIMEOUT_EN is defined.
module alu_rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_rr_arbiter_if.slave   bus
);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             alu_start;
  logic             timeout_err;

  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic             to_hit;
  logic             release_now;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] to_cnt;

  assign to_hit = (state == WAIT) && !bus.alu_done && (to_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == START) begin
      to_cnt <= '0;
    end else if ((state == WAIT) && !bus.alu_done) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  assign release_now = (state == WAIT) && (bus.alu_done || to_hit);

  // On release the next winner is chosen from the already-advanced pointer, enabling back-to-back grants.
  assign pick_ptr = (state == WAIT) ? (gnt_idx + IDX_W'(1)) : ptr;

  rr_pick u_pick (
    .req       (bus.req),
    .ptr       (pick_ptr),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      gnt         <= '0;
      gnt_idx     <= '0;
      gnt_valid   <= 1'b0;
      alu_start   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      alu_start   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            gnt_idx   <= win_idx;
            gnt       <= decode(win_idx);
            gnt_valid <= 1'b1;
            alu_start <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          if (release_now) begin
            ptr         <= pick_ptr;
            timeout_err <= to_hit;
            if (win_valid) begin
              gnt_idx   <= win_idx;
              gnt       <= decode(win_idx);
              alu_start <= 1'b1;
              state     <= START;
            end else begin
              gnt_idx   <= '0;
              gnt       <= '0;
              gnt_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt         = gnt;
  assign bus.gnt_idx     = gnt_idx;
  assign bus.gnt_valid   = gnt_valid;
  assign bus.alu_start   = alu_start;
  assign bus.timeout_err = timeout_err;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Randomized and directed bench for alu_rr_arbiter against a transaction-level reference model.
module tb_alu_rr_arbiter;
  import alu_arb_pkg::*;

  localparam int TIMEOUT = 16;
`ifdef ALU_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_rr_arbiter_if bus();

  alu_rr_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: phase 0 = no grant, 1 = launch cycle, 2 = waiting on ALU.
  int m_phase = 0;
  int m_ptr   = 0;
  int m_idx   = 0;
  int m_wcnt  = 0;
  bit m_valid = 1'b0;
  bit m_start = 1'b0;
  bit m_err   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [7:0] q, input logic d);
    bit tmo;
    m_start = 1'b0;
    m_err   = 1'b0;
    if (!r) begin
      m_phase = 0; m_ptr = 0; m_idx = 0; m_valid = 1'b0; m_wcnt = 0;
      return;
    end
    case (m_phase)
      0: begin
        if (q != 8'h00) begin
          m_idx = pick(q, m_ptr); m_valid = 1'b1; m_start = 1'b1; m_phase = 1;
        end
      end
      1: begin
        m_phase = 2; m_wcnt = 0;
      end
      default: begin
        tmo = TO_EN && !d && (m_wcnt == TIMEOUT - 1);
        if (d || tmo) begin
          m_err = tmo;
          m_ptr = (m_idx + 1) % 8;
          if (q != 8'h00) begin
            m_idx = pick(q, m_ptr); m_start = 1'b1; m_phase = 1;
          end else begin
            m_idx = 0; m_valid = 1'b0; m_phase = 0;
          end
        end else begin
          m_wcnt++;
        end
      end
    endcase
  endtask

  // One clock: drive inputs, advance model at the edge, compare on the falling edge.
  task automatic cyc(input logic r, input logic [7:0] q, input logic d);
    rst_n        = r;
    bus.req      = q;
    bus.alu_done = d;
    @(posedge clk);
    model_step(r, q, d);
    @(negedge clk);
    chk("gnt", 32'(bus.gnt), m_valid ? (32'd1 << m_idx) : 32'd0);
    chk("gnt_idx", 32'(bus.gnt_idx), 32'(m_idx));
    chk("gnt_valid", 32'(bus.gnt_valid), 32'(m_valid));
    chk("alu_start", 32'(bus.alu_start), 32'(m_start));
    chk("timeout_err", 32'(bus.timeout_err), 32'(m_err));
  endtask

  initial begin
    int err_pulses;
    int seen;
    logic [7:0] q;
    rst_n = 1'b0; bus.req = '0; bus.alu_done = 1'b0;
    @(negedge clk);

    // Reset held with all requests pending, then release and re-reset mid-WAIT.
    repeat (3) cyc(1'b0, 8'hFF, 1'b0);
    chk("rst_gnt", 32'(bus.gnt), 32'h00);
    chk("rst_start", 32'(bus.alu_start), 32'h0);
    cyc(1'b1, 8'hFF, 1'b0);
    chk("rst_rel_gnt", 32'(bus.gnt), 32'h01);
    chk("rst_rel_start", 32'(bus.alu_start), 32'h1);
    cyc(1'b1, 8'hFF, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0);
    cyc(1'b0, 8'hFF, 1'b1);
    chk("rst_wait_gnt", 32'(bus.gnt), 32'h00);
    cyc(1'b1, 8'hFF, 1'b0);
    chk("rst_again_idx", 32'(bus.gnt_idx), 32'h0);

    // Single requester 4.
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'h10, 1'b0);
    chk("single_gnt", 32'(bus.gnt), 32'h10);
    chk("single_idx", 32'(bus.gnt_idx), 32'h4);
    cyc(1'b1, 8'h00, 1'b0);
    chk("single_start_low", 32'(bus.alu_start), 32'h0);
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b1, 8'h00, 1'b1);
    chk("single_release", 32'(bus.gnt), 32'h00);

    // Fairness: all requesting, done one cycle after each start.
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0);
    for (int g = 0; g < 9; g++) begin
      chk("fair_start", 32'(bus.alu_start), 32'h1);
      chk("fair_seq", 32'(bus.gnt_idx), 32'(g % 8));
      cyc(1'b1, 8'hFF, 1'b0);
      cyc(1'b1, 8'hFF, 1'b1);
    end

    // Wrap/skip: finish a grant to 6, then requests 0 and 2.
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'h40, 1'b0);
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b1, 8'h00, 1'b1);
    cyc(1'b1, 8'h05, 1'b0);
    chk("wrap_first", 32'(bus.gnt_idx), 32'h0);
    cyc(1'b1, 8'h05, 1'b0);
    cyc(1'b1, 8'h05, 1'b1);
    chk("wrap_second", 32'(bus.gnt_idx), 32'h2);

    // Non-retraction and done-in-START ignored.
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'h08, 1'b0);
    cyc(1'b1, 8'h00, 1'b1);
    chk("nr_start_done", 32'(bus.gnt), 32'h08);
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b1, 8'h00, 1'b0);
    chk("nr_hold", 32'(bus.gnt), 32'h08);
    cyc(1'b1, 8'h00, 1'b1);
    chk("nr_release", 32'(bus.gnt), 32'h00);

    // Long wait without done.
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'h01, 1'b0);
    err_pulses = 0;
    for (int c = 0; c < 100; c++) begin
      cyc(1'b1, 8'h03, 1'b0);
      if (bus.timeout_err) err_pulses++;
    end
`ifdef ALU_ARB_TIMEOUT_EN
    chk("to_pulsed", 32'(err_pulses > 0), 32'h1);
`else
    chk("hold_gnt", 32'(bus.gnt), 32'h01);
    chk("hold_no_err", 32'(err_pulses), 32'h0);
`endif

    // Randomized traffic with occasional resets.
    seen = 0;
    for (int c = 0; c < 3000; c++) begin
      q = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 3) == 0) q = 8'h00;
      cyc(($urandom_range(0, 63) != 0), q, ($urandom_range(0, 3) == 0));
      if (bus.alu_start) seen++;
    end
    chk("rand_activity", 32'(seen > 100), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Round-robin arbiter sharing the single 32-bit ALU among up to 8 requesters, e.g. issue slots, the address-gen unit and the branch unit.
- Grants one requester at a time and presents the grant as an 8-bit one-hot vector plus a 3-bit encoded index; the index drives the ALU operand mux selects.
- Sequences each ALU transaction with a start pulse, waits for the ALU done, then rotates priority.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 to match the 3-bit index space.
- IDX_W, 3, encoded grant index width, log2(N_REQ).
- TIMEOUT, 16, max WAIT cycles before forced release; used only with ALU_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  Single clock, rising edge.
- rst_n  in  1  Synchronous, active-low reset.
- req  in  8  Per-requester request level; bit i = requester i.
- alu_done  in  1  ALU completion pulse; sampled only in WAIT.
- gnt  out  8  One-hot grant; all-zero when idle.
- gnt_idx  out  3  Encoded index of the granted requester; 0 when idle.
- gnt_valid  out  1  High while any grant is held.
- alu_start  out  1  One-cycle pulse launching the ALU operation for the granted requester.
- timeout_err  out  1  One-cycle pulse on forced release; tied 0 without the macro.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, state=IDLE, rr pointer ptr=0, timeout counter=0. This applies in any state, including mid-WAIT; no alu_start or timeout_err is emitted on reset.
- Pick function: the first set bit of req scanning upward from ptr, wrapping 7->0. It is combinational on the current req and ptr.
- States: IDLE, START, WAIT.
- IDLE:
  - If |req, latch the picked winner into gnt_idx, set gnt_valid=1 and gnt=decode(gnt_idx), then go to START.
  - Otherwise stay in IDLE with outputs 0.
- START:
  - alu_start=1 for exactly this cycle; grant held.
  - Go to WAIT unconditionally.
  - alu_done in this cycle is ignored.
- WAIT:
  - Grant held and alu_start=0.
  - On alu_done=1, set ptr <= gnt_idx+1 (mod 8).
  - If |req in that same cycle, pick the next winner using the updated ptr and go to START next cycle (back-to-back, no idle bubble).
  - Otherwise clear the grant and go to IDLE.
- Latency:
  - req rises in IDLE at cycle n -> gnt and alu_start at cycle n+1.
  - alu_done at cycle k -> next grant and alu_start at k+1.
- A granted requester dropping req during START or WAIT has no effect; the grant persists until alu_done. Grants are non-retractable.
- The winner's own req bit may still be set at release. It is eligible again, but only after all other requesters because ptr has advanced past it.
- Invariants: gnt is always one-hot or zero; gnt == (gnt_valid ? 1<<gnt_idx : 0); at most one alu_start per grant.

Optional Feature:
- Macro: ALU_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle without alu_done.
  - When it reaches TIMEOUT-1 without done, release exactly as if alu_done had arrived, including ptr advance and the back-to-back rule.
  - Pulse timeout_err=1 for that one cycle.
  - alu_done in that same cycle takes precedence, and no error is flagged.
- Not defined: no counter; WAIT holds indefinitely; timeout_err constant 0. The port list is identical either way.

Decomposition:
- Package alu_arb_pkg holds:
  - constants N_REQ and IDX_W;
  - state enum {IDLE, START, WAIT};
  - a decode function for index -> one-hot 8-bit.
- One natural combinational sub-module, rr_pick: inputs req[7:0] and ptr[2:0]; outputs win_idx[2:0] and win_valid.
- The FSM, ptr, timeout counter and output registers live in alu_rr_arbiter.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req=0xFF -> gnt=0x00, gnt_idx=0, gnt_valid=0, alu_start=0. Release -> next cycle gnt=0x01 and an alu_start pulse. Reassert rst_n in WAIT -> all outputs 0 next cycle, and the next grant is idx 0 again.
- Single request: req=0x10 at cycle 0 -> cycle 1 gnt=0x10, gnt_idx=4, alu_start=1; cycle 2 alu_start=0. alu_done at cycle 5 with req=0 -> cycle 6 gnt=0x00, state IDLE.
- Fairness: req=0xFF held, alu_done one cycle after each alu_start -> gnt_idx sequence 0,1,2,3,4,5,6,7,0, each grant spaced by START+WAIT with no IDLE cycles.
- Wrap/skip: after a grant to idx 6 completes (ptr=7), req=0x05 -> grant idx 0, then on its done grant idx 2.
- Non-retraction: granted idx 3 drops req in WAIT -> gnt stays 0x08 until alu_done. alu_done asserted in START -> ignored; still WAIT.
- Timeout: with ALU_ARB_TIMEOUT_EN and TIMEOUT=16, no alu_done -> timeout_err pulses exactly once on the 16th WAIT cycle and the grant releases or rotates. Without the macro, same stimulus -> gnt held for 100 cycles and timeout_err=0 throughout.
